// File: rtl/icetap_rec_ctrl_if.sv
// Command inputs, capture-RAM write port and run status of the trace recorder.
interface icetap_rec_ctrl_if #(
    parameter int unsigned ADDR_BITS = 9
);
    logic                 cmd_start;
    logic                 cmd_abort;
    logic                 trigger;
    logic                 store_en;
    logic [ADDR_BITS-1:0] post_len;
    logic                 ram_wr;
    logic [ADDR_BITS-1:0] ram_waddr;
    logic [1:0]           state;
    logic                 idle;
    logic                 trigger_seen;
    logic [ADDR_BITS-1:0] start_addr;
    logic [ADDR_BITS-1:0] trigger_addr;
    logic [ADDR_BITS-1:0] stop_addr;

    // Command / sample-qualifier source side
    modport master (
        output cmd_start, cmd_abort, trigger, store_en, post_len,
        input  ram_wr, ram_waddr, state, idle, trigger_seen,
        input  start_addr, trigger_addr, stop_addr
    );

    // Recorder control side
    modport slave (
        input  cmd_start, cmd_abort, trigger, store_en, post_len,
        output ram_wr, ram_waddr, state, idle, trigger_seen,
        output start_addr, trigger_addr, stop_addr
    );
endinterface

// File: rtl/icetap_rec_ctrl.sv
// Trace recorder control: circular pre-trigger capture, counted post-trigger
// capture, abort, and end-of-run window reporting for the capture RAM.
module icetap_rec_ctrl #(
    parameter int unsigned RECORD_DEPTH = 512,
    parameter int unsigned ADDR_BITS    = $clog2(RECORD_DEPTH)
) (
    input  logic              clk,
    input  logic              reset_,
    icetap_rec_ctrl_if.slave  bus
);

    // Write count needs one extra bit so it can hold RECORD_DEPTH itself.
    localparam int unsigned CNT_BITS = ADDR_BITS + 1;
    localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(RECORD_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_POST = 2'd2
    } state_t;

    state_t               state_q;
    logic [ADDR_BITS-1:0] waddr_q;
    logic [CNT_BITS-1:0]  wcnt_q;
    logic [ADDR_BITS-1:0] post_len_q;
    logic [ADDR_BITS-1:0] post_cnt_q;
    logic [ADDR_BITS-1:0] start_q;
    logic [ADDR_BITS-1:0] trig_q;
    logic [ADDR_BITS-1:0] stop_q;
    logic                 seen_q;

    logic                 wr;
    logic                 run_end;
    logic [CNT_BITS-1:0]  wcnt_nxt;
    logic [ADDR_BITS-1:0] last_addr;
    logic [ADDR_BITS-1:0] stop_nxt;
    logic [ADDR_BITS-1:0] start_nxt;

    // Write enable and end-of-run detection for the current sample
    always_comb begin
        wr      = 1'b0;
        run_end = 1'b0;
        case (state_q)
            S_PRE: begin
                wr      = ~bus.cmd_abort & (bus.store_en | bus.trigger);
                run_end = bus.cmd_abort |
                          (bus.trigger & (post_len_q == '0));
            end
            S_POST: begin
                wr      = ~bus.cmd_abort & bus.store_en;
                run_end = bus.cmd_abort |
                          (bus.store_en & (post_cnt_q == ADDR_BITS'(1)));
            end
            default: begin
                wr      = 1'b0;
                run_end = 1'b0;
            end
        endcase
    end

    // Window bounds as they will stand once the current sample is accounted for
    always_comb begin
        wcnt_nxt  = (wr && (wcnt_q != DEPTH_C)) ? wcnt_q + CNT_BITS'(1) : wcnt_q;
        last_addr = wr ? waddr_q : waddr_q - ADDR_BITS'(1);
        stop_nxt  = (wcnt_nxt == '0) ? '0 : last_addr;
        start_nxt = (wcnt_nxt == DEPTH_C) ? last_addr + ADDR_BITS'(1) : '0;
    end

    // Recording FSM, address/count tracking and status capture
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q    <= S_IDLE;
            waddr_q    <= '0;
            wcnt_q     <= '0;
            post_len_q <= '0;
            post_cnt_q <= '0;
            start_q    <= '0;
            trig_q     <= '0;
            stop_q     <= '0;
            seen_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.cmd_start && !bus.cmd_abort) begin
                        post_len_q <= bus.post_len;
                        waddr_q    <= '0;
                        wcnt_q     <= '0;
                        seen_q     <= 1'b0;
                        state_q    <= S_PRE;
                    end
                end
                S_PRE: begin
                    if (wr) begin
                        waddr_q <= waddr_q + ADDR_BITS'(1);
                        wcnt_q  <= wcnt_nxt;
                    end
                    if (bus.trigger && !bus.cmd_abort) begin
                        trig_q     <= waddr_q;
                        seen_q     <= 1'b1;
                        post_cnt_q <= post_len_q;
                        state_q    <= S_POST;
                    end
                end
                S_POST: begin
                    if (wr) begin
                        waddr_q    <= waddr_q + ADDR_BITS'(1);
                        wcnt_q     <= wcnt_nxt;
                        post_cnt_q <= post_cnt_q - ADDR_BITS'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Run ends: publish window; an abort before trigger parks trigger_addr on stop
            if (run_end) begin
                state_q <= S_IDLE;
                stop_q  <= stop_nxt;
                start_q <= start_nxt;
                if (bus.cmd_abort && !seen_q) begin
                    trig_q <= stop_nxt;
                end
            end
        end
    end

    assign bus.ram_wr       = wr;
    assign bus.ram_waddr    = waddr_q;
    assign bus.state        = state_q;
    assign bus.idle         = (state_q == S_IDLE);
    assign bus.trigger_seen = seen_q;
    assign bus.start_addr   = start_q;
    assign bus.trigger_addr = trig_q;
    assign bus.stop_addr    = stop_q;

endmodule

// File: tb/tb_icetap_rec_ctrl.sv
// Directed bench for the trace recorder control block.
module tb_icetap_rec_ctrl;

    localparam int unsigned DEPTH = 512;
    localparam int unsigned AB    = 9;

    logic clk = 1'b0;
    logic reset_;
    int   total = 0;
    int   bad = 0;
    int   wr_total = 0;
    int   w0 = 0;

    always #5 clk = ~clk;

    icetap_rec_ctrl_if #(.ADDR_BITS(AB)) bus ();

    icetap_rec_ctrl #(
        .RECORD_DEPTH(DEPTH),
        .ADDR_BITS   (AB)
    ) dut (
        .clk   (clk),
        .reset_(reset_),
        .bus   (bus)
    );

    // Count RAM writes mid-cycle, where ram_wr is stable
    always @(negedge clk) begin
        if (bus.ram_wr === 1'b1) wr_total++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        total++;
        assert (obs === 32'(exp))
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n = 0;
        while (bus.idle !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.idle), 1);
    endtask

    task automatic start_run(input int plen);
        bus.cmd_start = 1'b1;
        bus.post_len  = AB'(plen);
        tick();
        bus.cmd_start = 1'b0;
        w0 = wr_total;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with active-looking inputs
        reset_        = 1'b0;
        bus.cmd_start = 1'b0;
        bus.cmd_abort = 1'b0;
        bus.trigger   = 1'b1;
        bus.store_en  = 1'b1;
        bus.post_len  = '0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_idle", 32'(bus.idle), 1);
        chk("rst_ram_wr", 32'(bus.ram_wr), 0);
        chk("rst_waddr", 32'(bus.ram_waddr), 0);
        chk("rst_start", 32'(bus.start_addr), 0);
        chk("rst_trig", 32'(bus.trigger_addr), 0);
        chk("rst_stop", 32'(bus.stop_addr), 0);
        chk("rst_seen", 32'(bus.trigger_seen), 0);
        @(posedge clk);
        #1;
        reset_ = 1'b1;

        // Basic capture, started on the first cycle out of reset, trigger ignored at start
        bus.cmd_start = 1'b1;
        bus.post_len  = AB'(50);
        bus.trigger   = 1'b1;
        bus.store_en  = 1'b1;
        #2;
        chk("start_cycle_ram_wr", 32'(bus.ram_wr), 0);
        tick();
        bus.cmd_start = 1'b0;
        bus.trigger   = 1'b0;
        w0 = wr_total;
        chk("basic_pre_state", 32'(bus.state), 1);
        chk("basic_seen_cleared", 32'(bus.trigger_seen), 0);
        repeat (40) tick();
        bus.cmd_start = 1'b1;          // ignored outside IDLE
        bus.post_len  = AB'(7);
        tick();
        bus.cmd_start = 1'b0;
        repeat (59) tick();
        bus.trigger = 1'b1;
        #2;
        chk("basic_waddr_at_trig", 32'(bus.ram_waddr), 100);
        tick();
        bus.trigger = 1'b0;
        chk("basic_post_state", 32'(bus.state), 2);
        wait_idle(60, "basic_idle");
        bus.store_en = 1'b0;
        chk("basic_trig", 32'(bus.trigger_addr), 100);
        chk("basic_stop", 32'(bus.stop_addr), 150);
        chk("basic_start", 32'(bus.start_addr), 0);
        chk("basic_seen", 32'(bus.trigger_seen), 1);
        chk("basic_writes", 32'(wr_total - w0), 151);
        chk("basic_state", 32'(bus.state), 0);

        // Wrap-around
        start_run(100);
        bus.store_en = 1'b1;
        repeat (600) tick();
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        wait_idle(150, "wrap_idle");
        bus.store_en = 1'b0;
        chk("wrap_trig", 32'(bus.trigger_addr), 88);
        chk("wrap_stop", 32'(bus.stop_addr), 188);
        chk("wrap_start", 32'(bus.start_addr), 189);
        chk("wrap_writes", 32'(wr_total - w0), 701);

        // Zero post-trigger length
        start_run(0);
        bus.store_en = 1'b1;
        repeat (10) tick();
        bus.trigger = 1'b1;
        #2;
        chk("zero_trig_write", 32'(bus.ram_wr), 1);
        tick();
        bus.trigger = 1'b0;
        chk("zero_idle_next", 32'(bus.idle), 1);
        repeat (3) tick();
        bus.store_en = 1'b0;
        chk("zero_writes", 32'(wr_total - w0), 11);
        chk("zero_trig", 32'(bus.trigger_addr), 10);
        chk("zero_stop", 32'(bus.stop_addr), 10);
        chk("zero_start", 32'(bus.start_addr), 0);

        // Qualified store, trigger on an unqualified sample, trigger held during post
        start_run(5);
        for (int i = 0; i < 6; i++) begin
            bus.store_en = (i % 2 == 0);
            tick();
        end
        bus.store_en = 1'b0;
        bus.trigger  = 1'b1;
        #2;
        chk("qual_trig_written", 32'(bus.ram_wr), 1);
        tick();
        for (int j = 0; j < 40 && bus.idle !== 1'b1; j++) begin
            bus.store_en = (j % 2 == 0);
            tick();
        end
        bus.trigger  = 1'b0;
        bus.store_en = 1'b0;
        chk("qual_idle", 32'(bus.idle), 1);
        chk("qual_writes", 32'(wr_total - w0), 9);
        chk("qual_trig", 32'(bus.trigger_addr), 3);
        chk("qual_stop", 32'(bus.stop_addr), 8);
        chk("qual_start", 32'(bus.start_addr), 0);

        // Abort during post-trigger capture
        start_run(50);
        bus.store_en = 1'b1;
        repeat (5) tick();
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        repeat (20) tick();
        bus.cmd_abort = 1'b1;
        #2;
        chk("abort_no_write", 32'(bus.ram_wr), 0);
        tick();
        bus.cmd_abort = 1'b0;
        bus.store_en  = 1'b0;
        chk("abort_idle", 32'(bus.idle), 1);
        chk("abort_seen", 32'(bus.trigger_seen), 1);
        chk("abort_trig", 32'(bus.trigger_addr), 5);
        chk("abort_stop", 32'(bus.stop_addr), 25);
        chk("abort_start", 32'(bus.start_addr), 0);
        chk("abort_writes", 32'(wr_total - w0), 26);

        // Abort of a run with no writes
        start_run(3);
        repeat (3) tick();
        bus.cmd_abort = 1'b1;
        tick();
        bus.cmd_abort = 1'b0;
        chk("empty_idle", 32'(bus.idle), 1);
        chk("empty_stop", 32'(bus.stop_addr), 0);
        chk("empty_start", 32'(bus.start_addr), 0);
        chk("empty_trig", 32'(bus.trigger_addr), 0);

        // Abort in pre-trigger after some writes
        start_run(3);
        bus.store_en = 1'b1;
        repeat (7) tick();
        bus.cmd_abort = 1'b1;
        tick();
        bus.cmd_abort = 1'b0;
        bus.store_en  = 1'b0;
        chk("pre_abort_idle", 32'(bus.idle), 1);
        chk("pre_abort_seen", 32'(bus.trigger_seen), 0);
        chk("pre_abort_stop", 32'(bus.stop_addr), 6);
        chk("pre_abort_trig", 32'(bus.trigger_addr), 6);
        chk("pre_abort_start", 32'(bus.start_addr), 0);

        // Start and abort together in IDLE
        bus.cmd_start = 1'b1;
        bus.cmd_abort = 1'b1;
        bus.store_en  = 1'b1;
        tick();
        bus.cmd_start = 1'b0;
        bus.cmd_abort = 1'b0;
        chk("conflict_state", 32'(bus.state), 0);
        chk("conflict_idle", 32'(bus.idle), 1);
        #2;
        chk("conflict_no_write", 32'(bus.ram_wr), 0);
        chk("conflict_stop_held", 32'(bus.stop_addr), 6);
        tick();

        // Asynchronous reset in post-trigger capture, then a fresh run
        start_run(50);
        repeat (3) tick();
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        repeat (2) tick();
        chk("mid_post_state", 32'(bus.state), 2);
        #2;
        reset_ = 1'b0;
        #1;
        chk("arst_state", 32'(bus.state), 0);
        chk("arst_idle", 32'(bus.idle), 1);
        chk("arst_ram_wr", 32'(bus.ram_wr), 0);
        chk("arst_waddr", 32'(bus.ram_waddr), 0);
        chk("arst_trig", 32'(bus.trigger_addr), 0);
        chk("arst_stop", 32'(bus.stop_addr), 0);
        chk("arst_start", 32'(bus.start_addr), 0);
        chk("arst_seen", 32'(bus.trigger_seen), 0);
        tick();
        reset_ = 1'b1;
        start_run(2);
        repeat (4) tick();
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
        wait_idle(20, "rerun_idle");
        bus.store_en = 1'b0;
        chk("rerun_trig", 32'(bus.trigger_addr), 4);
        chk("rerun_stop", 32'(bus.stop_addr), 6);
        chk("rerun_start", 32'(bus.start_addr), 0);
        chk("rerun_seen", 32'(bus.trigger_seen), 1);
        chk("rerun_writes", 32'(wr_total - w0), 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icetap_rec_ctrl.md
ICETAP_REC_CTRL -- requirements
Module: icetap_rec_ctrl

Interface
REQ-001 Parameter RECORD_DEPTH, default 512, number of capture RAM entries; SHALL be a power of two, at least 4.
REQ-002 Parameter ADDR_BITS, default $clog2(RECORD_DEPTH), RAM address and status field width.
REQ-003 clk  input  1  single clock; capture RAM, trigger logic and this block all run on it.
REQ-004 reset_  input  1  reset, asynchronous and active-low.
REQ-005 cmd_start  input  1  single-cycle start pulse from the JTAG command synchronizer.
REQ-006 cmd_abort  input  1  single-cycle abort pulse from the JTAG command synchronizer.
REQ-007 trigger  input  1  trigger-mask match on the current signals_in sample.
REQ-008 store_en  input  1  store-mask qualifier for the current sample.
REQ-009 post_len  input  ADDR_BITS  number of samples to store after the trigger sample; sampled on accepted cmd_start.
REQ-010 ram_wr  output  1  capture RAM write enable for the current sample (combinational).
REQ-011 ram_waddr  output  ADDR_BITS  capture RAM write address (registered).
REQ-012 state  output  2  recording state: 0 IDLE, 1 PRE_TRIG, 2 POST_TRIG.
REQ-013 idle  output  1  high when state is IDLE.
REQ-014 trigger_seen  output  1  last run captured a trigger.
REQ-015 start_addr / trigger_addr / stop_addr  output  ADDR_BITS each  oldest valid entry / trigger sample entry / last written entry.

Function
REQ-016 In IDLE, cmd_start without cmd_abort SHALL latch post_len, clear ram_waddr, the saturating write count and trigger_seen, and move to PRE_TRIG on the next edge; ram_wr SHALL stay 0 in that cycle.
REQ-017 cmd_start outside IDLE SHALL be ignored.
REQ-018 In PRE_TRIG, ram_wr SHALL equal store_en OR trigger; the trigger sample is always stored.
REQ-019 In POST_TRIG, ram_wr SHALL equal store_en.
REQ-020 In IDLE, ram_wr SHALL be 0.
REQ-021 Every cycle with ram_wr=1: ram_waddr SHALL increment mod RECORD_DEPTH on the next edge; the write count SHALL increment, saturating at RECORD_DEPTH.
REQ-022 PRE_TRIG with trigger=1 SHALL set trigger_addr to the current ram_waddr and set trigger_seen.
REQ-023 On that same cycle, if latched post_len is 0 the block SHALL go to IDLE; otherwise it SHALL go to POST_TRIG with the post counter loaded to post_len.
REQ-024 In POST_TRIG, trigger SHALL be ignored; each write SHALL decrement the post counter; the write that brings it to 0 SHALL be the last write, and the block SHALL go to IDLE on the next edge.
REQ-025 On entry to IDLE from a run, stop_addr SHALL be the address of the last write.
REQ-026 On entry to IDLE from a run, start_addr SHALL be (stop_addr+1) mod RECORD_DEPTH if the write count reached RECORD_DEPTH, else 0.
REQ-027 A run that made zero writes SHALL end with start_addr = stop_addr = 0.
REQ-028 cmd_abort in PRE_TRIG or POST_TRIG SHALL return to IDLE on the next edge, with no write in the abort cycle.
REQ-029 On abort, stop_addr and start_addr SHALL follow REQ-025 to REQ-027.
REQ-030 On abort, trigger_seen SHALL keep its value, and trigger_addr SHALL become stop_addr if no trigger was seen.
REQ-031 cmd_abort and cmd_start in the same IDLE cycle: abort wins, start is ignored.
REQ-032 trigger in the cycle cmd_start is accepted SHALL be ignored.
REQ-033 Status outputs SHALL hold their values while IDLE, and SHALL be stable only while idle=1; mid-run values are undefined.

Reset
REQ-034 While reset_ is low, state SHALL be IDLE, idle=1, ram_wr=0, and ram_waddr, start_addr, trigger_addr, stop_addr, trigger_seen, the post counter and the write count SHALL all be 0.
REQ-035 Reset SHALL take effect asynchronously, including mid-run.
REQ-036 The first cycle after reset_ rises SHALL accept cmd_start.

Verification
REQ-037 Basic capture: store_en=1, post_len=50, trigger on the 101st write -> trigger_addr=100, stop_addr=150, start_addr=0, trigger_seen=1, 151 writes, idle=1.
REQ-038 Wrap-around: store_en=1, post_len=100, trigger on write index 600 -> trigger_addr=88, stop_addr=188, start_addr=189.
REQ-039 Zero post-trigger: post_len=0, trigger on write index 10 -> trigger_addr=10, stop_addr=10, idle=1 one cycle after the trigger cycle, no further writes.
REQ-040 Qualified store: store_en toggling, trigger arrives on a store_en=0 cycle -> that sample is written; post-trigger writes occur only on store_en=1 cycles; the post_len count is honoured exactly.
REQ-041 Abort: abort after 20 of 50 post-trigger writes -> idle next edge, trigger_seen=1, stop_addr=trigger_addr+20.
REQ-042 Abort and start conflicts: abort in PRE_TRIG with no trigger -> trigger_seen=0, trigger_addr=stop_addr; cmd_start and cmd_abort together in IDLE -> stays IDLE.
REQ-043 Async reset mid-POST_TRIG: drive reset_ low -> all outputs match REQ-034 immediately; a new run works correctly after release.
